// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle between the UART line, the uart_receiver and the UART controller.
// The receiver uses the slave modport; the controller/bench side uses master.
`timescale 1ns/1ps
interface uart_receiver_if;
   logic       rxd;
   logic       recv_reset;
   logic [7:0] recv_data;
   logic       recv_ok;
   logic       frame_error;
   logic       busy;
   logic [2:0] fsm_state;

   // recv_ok is a one-cycle strobe with no ready: the consumer must take recv_data that cycle.
   modport master (
      output rxd, recv_reset,
      input  recv_data, recv_ok, frame_error, busy, fsm_state
   );

   modport slave (
      input  rxd, recv_reset,
      output recv_data, recv_ok, frame_error, busy, fsm_state
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes rxd, frames characters, and strobes each good byte
// with recv_ok or a bad stop bit with frame_error.
`timescale 1ns/1ps
module uart_receiver #(
   parameter int CLK_PER_BIT = 868,
   parameter int SYNC_STAGES = 2
) (
   input logic           clk,
   input logic           reset_n,
   uart_receiver_if.slave rx
);

   localparam int CW = $clog2(CLK_PER_BIT);

   localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   logic [2:0]             state;
   logic [CW-1:0]          cnt;
   logic [2:0]             idx;
   logic [7:0]             shift;
   logic [7:0]             data_q;
   logic                   ok_q;
   logic                   fe_q;

   // Idle-high reset value keeps a spurious start bit from appearing out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx.rxd};
      end
   end

   assign rxd_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         idx    <= '0;
         shift  <= '0;
         data_q <= '0;
         ok_q   <= 1'b0;
         fe_q   <= 1'b0;
      end else begin
         ok_q <= 1'b0;
         fe_q <= 1'b0;
         if (rx.recv_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (!rxd_s) begin
                     state <= ST_START;
                     cnt   <= '0;
                  end
               end
               // Mid-start-bit check; a line that has already returned high was a glitch.
               ST_START: begin
                  if (cnt == HALF_M1) begin
                     cnt   <= '0;
                     idx   <= '0;
                     state <= rxd_s ? ST_IDLE : ST_DATA;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_DATA: begin
                  if (cnt == FULL_M1) begin
                     cnt   <= '0;
                     shift <= {rxd_s, shift[7:1]};
                     idx   <= idx + 1'b1;
                     if (idx == 3'd7) begin
                        state <= ST_STOP;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
               ST_STOP: begin
                  if (cnt == FULL_M1) begin
                     cnt <= '0;
                     if (rxd_s) begin
                        data_q <= shift;
                        ok_q   <= 1'b1;
                        state  <= ST_IDLE;
                     end else begin
                        fe_q  <= 1'b1;
                        state <= ST_BREAK;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_BREAK: begin
                  if (rxd_s) begin
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                  idx   <= '0;
               end
            endcase
         end
      end
   end

   assign rx.recv_data   = data_q;
   assign rx.recv_ok     = ok_q;
   assign rx.frame_error = fe_q;
   assign rx.busy        = (state != ST_IDLE);
   assign rx.fsm_state   = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 8 clocks per bit: framing, glitch rejection,
// break handling, back-to-back frames, and both reset paths.
`timescale 1ns/1ps
module tb_uart_receiver;

   logic clk;
   logic reset_n;
   int   cyc;
   int   test_cnt;
   int   fail_cnt;

   uart_receiver_if rx_if ();

   uart_receiver #(
      .CLK_PER_BIT (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (rx_if.slave)
   );

   // clock/reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // output monitor
   int         ok_cnt;
   int         fe_cnt;
   int         ok_cyc;
   int         fe_cyc;
   int         stray_cnt;
   int         both_cnt;
   int         dbl_cnt;
   logic [7:0] last_ok_data;
   logic [7:0] prev_data;
   logic       prev_ok;
   logic       prev_fe;
   logic [7:0] okd_q[$];
   int         okc_q[$];

   initial begin
      ok_cnt = 0; fe_cnt = 0; ok_cyc = 0; fe_cyc = 0;
      stray_cnt = 0; both_cnt = 0; dbl_cnt = 0;
      last_ok_data = 8'h00; prev_data = 8'h00; prev_ok = 1'b0; prev_fe = 1'b0;
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (rx_if.recv_ok) begin
            ok_cnt       <= ok_cnt + 1;
            ok_cyc       <= cyc;
            last_ok_data <= rx_if.recv_data;
            okd_q.push_back(rx_if.recv_data);
            okc_q.push_back(cyc);
         end
         if (rx_if.frame_error) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
         end
         if (rx_if.recv_ok && rx_if.frame_error) both_cnt <= both_cnt + 1;
         if ((rx_if.recv_ok && prev_ok) || (rx_if.frame_error && prev_fe)) dbl_cnt <= dbl_cnt + 1;
         if ((rx_if.recv_data !== prev_data) && !rx_if.recv_ok) stray_cnt <= stray_cnt + 1;
      end
      prev_data <= rx_if.recv_data;
      prev_ok   <= rx_if.recv_ok;
      prev_fe   <= rx_if.frame_error;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver: one 8N1 frame, optional recv_reset pulse / reset_n hit at cycle 4 / 2 of a frame bit
   logic       snap_pre_busy;
   logic       snap_rr_busy;
   logic [7:0] snap_data;
   logic       snap_ok;
   logic       snap_fe;
   logic       snap_busy;
   logic [2:0] snap_state;

   task automatic send_frame(input logic [7:0] d, input logic stop, input int rr_bit,
                             input int rn_bit, output int t0);
      logic [9:0] bits;
      logic       aborted;
      logic       rn_pend;
      bits    = {stop, d, 1'b0};
      aborted = 1'b0;
      rn_pend = 1'b0;
      t0      = cyc + 1;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < 8; c++) begin
            rx_if.rxd = aborted ? 1'b1 : bits[i];
            if (rx_if.recv_reset) begin
               rx_if.recv_reset = 1'b0;
               snap_rr_busy     = rx_if.busy;
            end
            if (rn_pend) begin
               #2 reset_n = 1'b1;
               rn_pend = 1'b0;
            end
            if (i == rr_bit && c == 4) begin
               snap_pre_busy    = rx_if.busy;
               rx_if.recv_reset = 1'b1;
               aborted          = 1'b1;
            end
            if (i == rn_bit && c == 2) begin
               snap_pre_busy = rx_if.busy;
               #2 reset_n = 1'b0;
               #1;
               snap_data  = rx_if.recv_data;
               snap_ok    = rx_if.recv_ok;
               snap_fe    = rx_if.frame_error;
               snap_busy  = rx_if.busy;
               snap_state = rx_if.fsm_state;
               rn_pend    = 1'b1;
            end
            @(negedge clk);
         end
      end
      if (rn_pend) #2 reset_n = 1'b1;
   endtask

   int t0;
   int t0a;
   int ok0;
   int fe0;
   int n0;

   initial begin
      test_cnt = 0;
      fail_cnt = 0;
      reset_n  = 1'b0;
      rx_if.rxd        = 1'b1;
      rx_if.recv_reset = 1'b0;
      snap_pre_busy = 1'b0; snap_rr_busy = 1'b1;
      snap_data = 8'hFF; snap_ok = 1'b1; snap_fe = 1'b1; snap_busy = 1'b1; snap_state = 3'd7;
      repeat (3) @(negedge clk);
      chk("rst_data",  32'(rx_if.recv_data),   32'h00);
      chk("rst_ok",    32'(rx_if.recv_ok),     32'h0);
      chk("rst_fe",    32'(rx_if.frame_error), 32'h0);
      chk("rst_busy",  32'(rx_if.busy),        32'h0);
      chk("rst_state", 32'(rx_if.fsm_state),   32'h0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 0xA5, recv_ok at t0+78
      ok0 = ok_cnt; fe0 = fe_cnt;
      send_frame(8'hA5, 1'b1, -1, -1, t0);
      repeat (4) @(negedge clk);
      chk("a5_ok_cnt", 32'(ok_cnt - ok0),  32'd1);
      chk("a5_data",   32'(last_ok_data),  32'hA5);
      chk("a5_lat",    32'(ok_cyc - t0),   32'd78);
      chk("a5_fe_cnt", 32'(fe_cnt - fe0),  32'd0);
      chk("a5_busy",   32'(rx_if.busy),    32'h0);

      // two-cycle glitch: busy rises after edge t0+2, then START rejects it
      ok0 = ok_cnt; fe0 = fe_cnt;
      rx_if.rxd = 1'b0;
      t0 = cyc + 1;
      @(negedge clk);
      @(negedge clk);
      chk("gl_busy_early", 32'(rx_if.busy), 32'h0);
      rx_if.rxd = 1'b1;
      @(negedge clk);
      chk("gl_busy_rise", 32'(rx_if.busy), 32'h1);
      chk("gl_rise_cyc",  32'(cyc - t0),   32'd2);
      repeat (10) @(negedge clk);
      chk("gl_busy_fall", 32'(rx_if.busy),      32'h0);
      chk("gl_ok_cnt",    32'(ok_cnt - ok0),    32'd0);
      chk("gl_fe_cnt",    32'(fe_cnt - fe0),    32'd0);
      chk("gl_data",      32'(rx_if.recv_data), 32'hA5);

      // 0x3C with a low stop bit, line held low: one frame_error, then break until release
      ok0 = ok_cnt; fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, -1, -1, t0);
      repeat (40) @(negedge clk);
      chk("brk_fe_cnt", 32'(fe_cnt - fe0),    32'd1);
      chk("brk_fe_lat", 32'(fe_cyc - t0),     32'd78);
      chk("brk_ok_cnt", 32'(ok_cnt - ok0),    32'd0);
      chk("brk_data",   32'(rx_if.recv_data), 32'hA5);
      chk("brk_busy",   32'(rx_if.busy),      32'h1);
      chk("brk_state",  32'(rx_if.fsm_state), 32'd4);
      rx_if.rxd = 1'b1;
      repeat (5) @(negedge clk);
      chk("brk_release", 32'(rx_if.busy), 32'h0);
      ok0 = ok_cnt;
      send_frame(8'h81, 1'b1, -1, -1, t0);
      repeat (4) @(negedge clk);
      chk("x81_ok_cnt", 32'(ok_cnt - ok0), 32'd1);
      chk("x81_data",   32'(last_ok_data), 32'h81);

      // back-to-back 0x00, 0xFF, 0x55 with a single stop bit each
      ok0 = ok_cnt; fe0 = fe_cnt;
      n0  = okd_q.size();
      send_frame(8'h00, 1'b1, -1, -1, t0a);
      send_frame(8'hFF, 1'b1, -1, -1, t0);
      send_frame(8'h55, 1'b1, -1, -1, t0);
      repeat (4) @(negedge clk);
      chk("b2b_ok_cnt", 32'(ok_cnt - ok0), 32'd3);
      chk("b2b_fe_cnt", 32'(fe_cnt - fe0), 32'd0);
      if (okd_q.size() >= n0 + 3) begin
         chk("b2b_d0",   32'(okd_q[n0]),     32'h00);
         chk("b2b_d1",   32'(okd_q[n0 + 1]), 32'hFF);
         chk("b2b_d2",   32'(okd_q[n0 + 2]), 32'h55);
         chk("b2b_lat0", 32'(okc_q[n0] - t0a), 32'd78);
         chk("b2b_gap1", 32'(okc_q[n0 + 1] - okc_q[n0]),     32'd80);
         chk("b2b_gap2", 32'(okc_q[n0 + 2] - okc_q[n0 + 1]), 32'd80);
      end

      // recv_reset during data bit 4 of 0x96; the sender abandons the frame
      ok0 = ok_cnt; fe0 = fe_cnt;
      send_frame(8'h96, 1'b1, 5, -1, t0);
      repeat (20) @(negedge clk);
      chk("rr_busy_before", 32'(snap_pre_busy),   32'h1);
      chk("rr_busy_after",  32'(snap_rr_busy),    32'h0);
      chk("rr_ok_cnt",      32'(ok_cnt - ok0),    32'd0);
      chk("rr_fe_cnt",      32'(fe_cnt - fe0),    32'd0);
      chk("rr_data",        32'(rx_if.recv_data), 32'h55);
      send_frame(8'h69, 1'b1, -1, -1, t0);
      repeat (4) @(negedge clk);
      chk("x69_ok_cnt", 32'(ok_cnt - ok0), 32'd1);
      chk("x69_data",   32'(last_ok_data), 32'h69);

      // reset_n in the middle of the stop bit of 0x77
      ok0 = ok_cnt; fe0 = fe_cnt;
      send_frame(8'h77, 1'b1, -1, 9, t0);
      repeat (4) @(negedge clk);
      chk("rn_stop_busy_pre", 32'(snap_pre_busy), 32'h1);
      chk("rn_stop_data",     32'(snap_data),     32'h00);
      chk("rn_stop_ok",       32'(snap_ok),       32'h0);
      chk("rn_stop_fe",       32'(snap_fe),       32'h0);
      chk("rn_stop_busy",     32'(snap_busy),     32'h0);
      chk("rn_stop_state",    32'(snap_state),    32'h0);
      chk("rn_stop_ok_cnt",   32'(ok_cnt - ok0),  32'd0);
      chk("rn_stop_fe_cnt",   32'(fe_cnt - fe0),  32'd0);

      // good 0xC3, then reset_n between edges clears recv_data immediately
      send_frame(8'hC3, 1'b1, -1, -1, t0);
      repeat (4) @(negedge clk);
      chk("xc3_data", 32'(last_ok_data), 32'hC3);
      #2 reset_n = 1'b0;
      #1;
      chk("rn_idle_data", 32'(rx_if.recv_data),   32'h00);
      chk("rn_idle_ok",   32'(rx_if.recv_ok),     32'h0);
      chk("rn_idle_fe",   32'(rx_if.frame_error), 32'h0);
      chk("rn_idle_busy", 32'(rx_if.busy),        32'h0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      ok0 = ok_cnt;
      send_frame(8'h5A, 1'b1, -1, -1, t0);
      repeat (4) @(negedge clk);
      chk("x5a_ok_cnt", 32'(ok_cnt - ok0), 32'd1);
      chk("x5a_data",   32'(last_ok_data), 32'h5A);
      chk("x5a_lat",    32'(ok_cyc - t0),  32'd78);

      // whole-run output rules
      chk("ok_fe_overlap", 32'(both_cnt),  32'd0);
      chk("double_pulse",  32'(dbl_cnt),   32'd0);
      chk("stray_data",    32'(stray_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
